// File: rtl/ir_operand_wb_path.sv
// Datapath slice of the multicycle RV64 core: instruction register with field
// decode, ALU operand-B select (Mux1) and register-file write-back select (Mux2).
module ir_operand_wb_path #(
  parameter int unsigned          XLEN     = 64,
  parameter int unsigned          ILEN     = 32,
  parameter logic [ILEN-1:0]      IR_RESET = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            ir_we,
  input  logic [ILEN-1:0] ir_din,
  output logic [ILEN-1:0] ir_dout,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] doutB,
  input  logic            sel_b,
  output logic [XLEN-1:0] S1,
  input  logic [XLEN-1:0] mem_dout,
  input  logic [XLEN-1:0] alu_res,
  input  logic            sel_wb,
  output logic [XLEN-1:0] S2
);

  // No handshake here: ir_we, sel_b and sel_wb come straight from the
  // controller and are sampled (ir_we) or used combinationally (selects) as-is.

  logic [ILEN-1:0] ir_q;

  // Reset is asynchronous and wins over ir_we; otherwise load only when enabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_q <= IR_RESET;
    end else if (ir_we) begin
      ir_q <= ir_din;
    end
  end

  assign ir_dout = ir_q;

  // Standard RISC-V field positions; decode is a pure slice of the held word.
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

  // imm arrives already sign-extended, so both muxes are bit-exact pass-throughs.
  assign S1 = sel_b  ? doutB    : imm;
  assign S2 = sel_wb ? mem_dout : alu_res;

endmodule

// File: tb/tb_ir_operand_wb_path.sv
// Self-checking bench for ir_operand_wb_path: directed scenarios plus a randomized
// run checked against a behavioural model of the IR and the two select muxes.
module tb_ir_operand_wb_path;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  logic            clock;
  logic            reset_n;
  logic            ir_we;
  logic [ILEN-1:0] ir_din;
  logic [ILEN-1:0] ir_dout;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] doutB;
  logic            sel_b;
  logic [XLEN-1:0] S1;
  logic [XLEN-1:0] mem_dout;
  logic [XLEN-1:0] alu_res;
  logic            sel_wb;
  logic [XLEN-1:0] S2;

  int vectors    = 0;
  int miscompares = 0;

  logic [ILEN-1:0] model_ir;
  logic [ILEN-1:0] exp_q[$];

  ir_operand_wb_path #(.XLEN(XLEN), .ILEN(ILEN), .IR_RESET(32'h0000_0000)) dut (
    .clock(clock), .reset_n(reset_n),
    .ir_we(ir_we), .ir_din(ir_din), .ir_dout(ir_dout),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .imm(imm), .doutB(doutB), .sel_b(sel_b), .S1(S1),
    .mem_dout(mem_dout), .alu_res(alu_res), .sel_wb(sel_wb), .S2(S2)
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected decode, packed {opcode, rd, funct3, rs1, rs2, funct7}, by arithmetic.
  function automatic logic [31:0] exp_fields(input logic [31:0] ir);
    int unsigned w;
    logic [6:0] op, f7;
    logic [4:0] d, s1, s2;
    logic [2:0] f3;
    w  = ir;
    op = 7'(w % 128);
    d  = 5'((w / 128) % 32);
    f3 = 3'((w / 4096) % 8);
    s1 = 5'((w / 32768) % 32);
    s2 = 5'((w / 1048576) % 32);
    f7 = 7'(w / 33554432);
    return {op, d, f3, s1, s2, f7};
  endfunction

  function automatic logic [XLEN-1:0] mux_model(input logic sel, input logic [XLEN-1:0] one,
                                                 input logic [XLEN-1:0] zero);
    if (sel == 1'b1) return one;
    return zero;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    ir_we   = 1'b1;
    ir_din  = 32'h0020_8663;
    @(posedge clock); #1;
    vectors++;
    if (ir_dout !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ir: got %h expected %h", ir_dout, 32'h0);
    end
    vectors++;
    if ({opcode, rd, funct3, rs1, rs2, funct7} !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_fields: got %h expected 0", {opcode, rd, funct3, rs1, rs2, funct7});
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    vectors++;
    if (ir_dout !== 32'h0020_8663) begin
      miscompares++;
      $display("FAIL reset_first_load: got %h expected %h", ir_dout, 32'h0020_8663);
    end
    vectors++;
    if (opcode !== 7'h63 || rs1 !== 5'd1 || rs2 !== 5'd2 || funct3 !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_first_fields: got op=%h rs1=%0d rs2=%0d f3=%0d expected op=63 rs1=1 rs2=2 f3=0",
               opcode, rs1, rs2, funct3);
    end
  endtask

  task automatic test_ir_load_hold();
    @(negedge clock);
    ir_we  = 1'b1;
    ir_din = 32'h0031_00b3;
    @(posedge clock); #1;
    vectors++;
    if (rd !== 5'd1 || rs1 !== 5'd2 || rs2 !== 5'd3 || funct7 !== 7'd0) begin
      miscompares++;
      $display("FAIL load_fields: got rd=%0d rs1=%0d rs2=%0d f7=%h expected rd=1 rs1=2 rs2=3 f7=0",
               rd, rs1, rs2, funct7);
    end
    @(negedge clock);
    ir_we  = 1'b0;
    ir_din = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      vectors++;
      if (ir_dout !== 32'h0031_00b3) begin
        miscompares++;
        $display("FAIL hold_edge%0d: got %h expected %h", i, ir_dout, 32'h0031_00b3);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    ir_we  = 1'b1;
    ir_din = 32'h00a0_0093;
    @(posedge clock); #1;
    vectors++;
    if (ir_dout !== 32'h00a0_0093) begin
      miscompares++;
      $display("FAIL async_preload: got %h expected %h", ir_dout, 32'h00a0_0093);
    end
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    vectors++;
    if (ir_dout !== 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected 0 before next edge", ir_dout);
    end
    @(negedge clock);
    reset_n = 1'b1;
    ir_we   = 1'b0;
  endtask

  task automatic test_mux1();
    imm   = 64'hFFFF_FFFF_FFFF_FFFE;
    doutB = 64'd7;
    sel_b = 1'b1;
    #1;
    vectors++;
    if (S1 !== 64'd7) begin
      miscompares++;
      $display("FAIL mux1_doutB: got %h expected %h", S1, 64'd7);
    end
    sel_b = 1'b0;
    #1;
    vectors++;
    if (S1 !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      miscompares++;
      $display("FAIL mux1_imm: got %h expected %h", S1, 64'hFFFF_FFFF_FFFF_FFFE);
    end
    reset_n = 1'b0;
    @(posedge clock); #1;
    vectors++;
    if (S1 !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      miscompares++;
      $display("FAIL mux1_clk_rst: got %h expected %h", S1, 64'hFFFF_FFFF_FFFF_FFFE);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_mux2();
    mem_dout = 64'h8000_0000_0000_0001;
    alu_res  = 64'd12;
    sel_wb   = 1'b1;
    #1;
    vectors++;
    if (S2 !== 64'h8000_0000_0000_0001) begin
      miscompares++;
      $display("FAIL mux2_mem: got %h expected %h", S2, 64'h8000_0000_0000_0001);
    end
    sel_wb = 1'b0;
    #1;
    vectors++;
    if (S2 !== 64'd12) begin
      miscompares++;
      $display("FAIL mux2_alu: got %h expected %h", S2, 64'd12);
    end
    alu_res = 64'd5;
    #0;
    #0;
    vectors++;
    if (S2 !== 64'd5) begin
      miscompares++;
      $display("FAIL mux2_same_step: got %h expected %h", S2, 64'd5);
    end
  endtask

  task automatic test_addi();
    @(negedge clock);
    ir_we   = 1'b1;
    ir_din  = 32'h0050_0093;
    imm     = 64'd5;
    sel_b   = 1'b0;
    sel_wb  = 1'b0;
    alu_res = 64'd5;
    doutB   = 64'h1234;
    mem_dout = 64'hDEAD;
    @(posedge clock); #1;
    vectors++;
    if (S1 !== 64'd5 || S2 !== 64'd5) begin
      miscompares++;
      $display("FAIL addi_ops: got S1=%h S2=%h expected 5 and 5", S1, S2);
    end
    vectors++;
    if (rd !== 5'd1 || opcode !== 7'h13) begin
      miscompares++;
      $display("FAIL addi_fields: got rd=%0d op=%h expected rd=1 op=13", rd, opcode);
    end
    @(negedge clock);
    ir_we = 1'b0;
  endtask

  task automatic test_random();
    logic [ILEN-1:0] exp_ir;
    model_ir = ir_dout === ir_dout ? 32'h0050_0093 : 32'h0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      ir_we    = 1'($urandom_range(0, 1));
      ir_din   = $urandom;
      sel_b    = 1'($urandom_range(0, 1));
      sel_wb   = 1'($urandom_range(0, 1));
      imm      = {$urandom, $urandom};
      doutB    = {$urandom, $urandom};
      mem_dout = {$urandom, $urandom};
      alu_res  = {$urandom, $urandom};
      reset_n  = ($urandom_range(0, 19) != 0);
      if (!reset_n) model_ir = 32'h0;
      #1;
      vectors++;
      if (S1 !== mux_model(sel_b, doutB, imm) || S2 !== mux_model(sel_wb, mem_dout, alu_res)) begin
        miscompares++;
        $display("FAIL rand_mux[%0d]: got S1=%h S2=%h expected S1=%h S2=%h", i, S1, S2,
                 mux_model(sel_b, doutB, imm), mux_model(sel_wb, mem_dout, alu_res));
      end
      if (!reset_n) begin
        vectors++;
        if (ir_dout !== 32'h0) begin
          miscompares++;
          $display("FAIL rand_async_rst[%0d]: got %h expected 0", i, ir_dout);
        end
      end
      @(posedge clock);
      if (reset_n && ir_we) model_ir = ir_din;
      exp_q.push_back(model_ir);
      #1;
      exp_ir = exp_q.pop_front();
      vectors++;
      if (ir_dout !== exp_ir || {opcode, rd, funct3, rs1, rs2, funct7} !== exp_fields(exp_ir)) begin
        miscompares++;
        $display("FAIL rand_ir[%0d]: got ir=%h fields=%h expected ir=%h fields=%h", i, ir_dout,
                 {opcode, rd, funct3, rs1, rs2, funct7}, exp_ir, exp_fields(exp_ir));
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
    ir_we   = 1'b0;
  endtask

  initial begin
    ir_we = 1'b0; ir_din = '0; imm = '0; doutB = '0; sel_b = 1'b0;
    mem_dout = '0; alu_res = '0; sel_wb = 1'b0; reset_n = 1'b0;
    test_reset();
    test_ir_load_hold();
    test_async_reset();
    test_mux1();
    test_mux2();
    test_addi();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ir_operand_wb_path.md
Name: ir_operand_wb_path

Overview:
- Datapath slice for the multicycle RV64 core.
- Contains the instruction register (IR) with field decode.
- Contains the ALU operand-B select mux (Mux1: immediate vs register-file doutB).
- Contains the register-file write-back mux (Mux2: data-memory dout vs ALU result).
- Sits between instruction memory/imm generator, register file, ALU and data memory.

Parameters:
XLEN, 64, data-path width of operands, immediate, memory data and ALU result
ILEN, 32, instruction width
IR_RESET, 32'h0000_0000, value loaded into IR on reset

Ports:
clock  in  1  system clock, rising-edge active
reset_n  in  1  asynchronous active-low reset
ir_we  in  1  IR load enable (r_enable)
ir_din  in  ILEN  instruction word from instruction memory
ir_dout  out  ILEN  registered instruction (feeds imm generator)
opcode  out  7  ir_dout[6:0]
rd  out  5  ir_dout[11:7]
funct3  out  3  ir_dout[14:12]
rs1  out  5  ir_dout[19:15]
rs2  out  5  ir_dout[24:20]
funct7  out  7  ir_dout[31:25]
imm  in  XLEN  signed immediate from imm generator
doutB  in  XLEN  register-file read port B
sel_b  in  1  Mux1 select: 1 = doutB, 0 = imm
S1  out  XLEN  ALU operand B
mem_dout  in  XLEN  data-memory read data
alu_res  in  XLEN  ALU result (soma)
sel_wb  in  1  Mux2 select: 1 = mem_dout, 0 = alu_res
S2  out  XLEN  register-file write data (din)

Behaviour:
- IR register:
  - reset_n low: ir_dout = IR_RESET immediately, without waiting for a clock edge.
  - Reset overrides ir_we.
  - While reset_n is low, the register holds IR_RESET.
  - reset_n released: first load occurs at the next rising edge with ir_we=1.
  - Rising edge with ir_we=1: ir_dout <= ir_din, one-cycle latency.
  - ir_we=0: hold the current value indefinitely.
  - ir_din changes between edges have no effect on ir_dout.
- Decode fields:
  - opcode, rd, funct3, rs1, rs2 and funct7 are pure combinational slices of ir_dout.
  - They change only when ir_dout changes.
  - After reset they are all zero.
- Mux1:
  - Purely combinational, zero latency.
  - Not affected by clock or reset.
  - S1 = sel_b ? doutB : imm.
  - Bit-exact pass-through of all XLEN bits; no sign or width manipulation.
  - imm is already sign-extended upstream.
- Mux2:
  - Purely combinational, zero latency.
  - Not affected by clock or reset.
  - S2 = sel_wb ? mem_dout : alu_res.
  - Bit-exact pass-through of all XLEN bits.
- X/Z on a select: outputs follow standard Verilog conditional-operator semantics. Verification does not check this case.
- No handshake. Control signals (ir_we, sel_b, sel_wb) come from the controller and are sampled or used as-is.
- Usage per instruction class:
  - Branches, R-type add/sub: sel_b=1.
  - addi, loads, stores: sel_b=0.
  - Loads: sel_wb=1.
  - All other writes: sel_wb=0.

Test Plan:
- Reset: reset_n=0 with ir_we=1 and ir_din=32'h00208663 across a rising edge -> ir_dout=0 and all fields=0; reset_n=1, next edge -> ir_dout=32'h00208663, opcode=7'h63, rs1=1, rs2=2, funct3=0.
- IR load/hold: load 32'h003100b3 with ir_we=1 -> rd=1, rs1=2, rs2=3, funct7=0; then ir_we=0 with ir_din=32'hFFFFFFFF for 3 edges -> ir_dout stays 32'h003100b3.
- Async reset mid-operation: ir_dout=32'h00a00093, drive reset_n low between edges -> ir_dout=0 before the next edge.
- Mux1: imm=-2 (64'hFFFF_FFFF_FFFF_FFFE), doutB=64'd7; sel_b=1 -> S1=7; sel_b=0 -> S1=64'hFFFF_FFFF_FFFF_FFFE; toggling clock and reset has no effect.
- Mux2: mem_dout=64'h8000_0000_0000_0001, alu_res=64'd12; sel_wb=1 -> S2=64'h8000_0000_0000_0001; sel_wb=0 -> S2=12; changing alu_res to 5 with sel_wb=0 -> S2=5 in the same timestep.
- Combined addi path: IR loaded with 32'h00500093 (addi x1,x0,5), imm=5, sel_b=0, sel_wb=0, alu_res=5 -> S1=5, S2=5, rd=1, opcode=7'h13.
